// File: rtl/yannickreiss_seq_muldiv.sv
// Sequential unsigned shift-add multiplier / restoring divider, one result bit per clock.
// Latency: WIDTH CALC cycles, divide-by-zero skips CALC; MULDIV_EARLY_EXIT_EN shortens multiplies.
// Backpressure: none; start is taken only in IDLE or DONE and ignored while busy.
module yannickreiss_seq_muldiv #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_mode_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;

    logic               accept;
    logic               start_div0;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               calc_last;
`ifdef MULDIV_EARLY_EXIT_EN
    logic               rest_zero;
    logic [2*WIDTH-1:0] prod_full;
`endif

    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign start_div0 = op_code && (op_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = start_div0 ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (calc_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CALC);
        done = (state_q == ST_DONE);
    end

    // One iteration: acc_lo holds the multiplier (mul) or the dividend/quotient (div).
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opnd_q});
        if (op_mode_q) begin
            nxt_hi = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : WIDTH'(div_sh);
            nxt_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        res_hi    = nxt_hi;
        res_lo    = nxt_lo;
        calc_last = (cnt_q == CNT_W'(1));
`ifdef MULDIV_EARLY_EXIT_EN
        // Remaining multiplier bits are zero: the rest of the iterations would only shift.
        rest_zero = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((CNT_W'(i) < cnt_q) && acc_lo_q[i]) begin
                rest_zero = 1'b0;
            end
        end
        prod_full = {nxt_hi, nxt_lo} >> (cnt_q - CNT_W'(1));
        if (!op_mode_q && rest_zero) begin
            res_hi    = prod_full[2*WIDTH-1:WIDTH];
            res_lo    = prod_full[WIDTH-1:0];
            calc_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_mode_q   <= 1'b0;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_mode_q   <= op_code;
            div_by_zero <= start_div0;
            if (start_div0) begin
                result_lo <= '1;
                result_hi <= op_a;
            end else begin
                cnt_q    <= CNT_W'(WIDTH);
                opnd_q   <= op_code ? op_b : op_a;
                acc_hi_q <= '0;
                acc_lo_q <= op_code ? op_a : op_b;
            end
        end else if (state_q == ST_CALC) begin
            cnt_q    <= cnt_q - CNT_W'(1);
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
            if (calc_last) begin
                result_hi <= res_hi;
                result_lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_yannickreiss_seq_muldiv.sv
// Bench for yannickreiss_seq_muldiv: WIDTH=8 and WIDTH=3 instances against an arithmetic model.
module tb_yannickreiss_seq_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, code8, busy8, done8, dbz8;
    logic [7:0] a8, b8, hi8, lo8;
    logic       start3, code3, busy3, done3, dbz3;
    logic [2:0] a3, b3, hi3, lo3;

    int errors = 0;
    int checks = 0;
    int exp_hi8 = 0;
    int exp_lo8 = 0;
    bit exp_dz8 = 1'b0;

    yannickreiss_seq_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_code(code8), .op_a(a8), .op_b(b8),
        .busy(busy8), .done(done8), .result_hi(hi8), .result_lo(lo8), .div_by_zero(dbz8)
    );

    yannickreiss_seq_muldiv #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op_code(code3), .op_a(a3), .op_b(b3),
        .busy(busy3), .done(done3), .result_hi(hi3), .result_lo(lo3), .div_by_zero(dbz3)
    );

    function automatic int exp_calc(input logic code, input int b, input int width);
        int n;
        n = width;
        if (code && b == 0) n = 0;
`ifdef MULDIV_EARLY_EXIT_EN
        else if (!code) begin
            n = 1;
            for (int i = 0; i < width; i++) if (((b >> i) & 1) != 0) n = i + 1;
        end
`endif
        return n;
    endfunction

    function automatic void ref_model(input logic code, input int a, input int b, input int width,
                                      output int hi, output int lo, output bit dz);
        int mask;
        int p;
        mask = (1 << width) - 1;
        dz = 1'b0;
        if (!code) begin
            p  = a * b;
            hi = (p >> width) & mask;
            lo = p & mask;
        end else if (b == 0) begin
            hi = a;
            lo = mask;
            dz = 1'b1;
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    task automatic issue8(input logic code, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; code8 = code; a8 = a; b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); code8 = 1'($urandom);
    endtask

    // Waits for done after issue8; returns at the falling edge inside the done cycle.
    task automatic finish8(input logic code, input logic [7:0] a, input logic [7:0] b,
                           input bit noise, input string name);
        int hi, lo, ec, k, nbusy;
        bit dz, seen;
        ref_model(code, int'(a), int'(b), 8, hi, lo, dz);
        ec = exp_calc(code, int'(b), 8);
        k = 0; nbusy = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (done8) begin
                seen = 1'b1;
            end else if (busy8) begin
                nbusy++;
                if (nbusy == 1) begin
                    checks++;
                    if (hi8 !== 8'(exp_hi8) || lo8 !== 8'(exp_lo8) || dbz8 !== 1'b0) begin
                        errors++;
                        $display("FAIL %s hold_in_calc: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=0",
                                 name, hi8, lo8, dbz8, 8'(exp_hi8), 8'(exp_lo8));
                    end
                end
                if (noise) begin
                    start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); code8 = 1'($urandom);
                end
            end
        end
        start8 = 1'b0;
        checks++;
        if (!seen || k != ec + 1) begin
            errors++;
            $display("FAIL %s latency: done seen=%0b at cycle %0d, want cycle %0d", name, seen, k, ec + 1);
        end
        checks++;
        if (nbusy != ec) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", name, nbusy, ec);
        end
        checks++;
        if (hi8 !== 8'(hi) || lo8 !== 8'(lo)) begin
            errors++;
            $display("FAIL %s result (%0d op%0d %0d): got hi=%h lo=%h, want hi=%h lo=%h",
                     name, a, code, b, hi8, lo8, 8'(hi), 8'(lo));
        end
        checks++;
        if (dbz8 !== dz) begin
            errors++;
            $display("FAIL %s div_by_zero: got %b, want %b", name, dbz8, dz);
        end
        exp_hi8 = hi; exp_lo8 = lo; exp_dz8 = dz;
    endtask

    task automatic check_hold8(input string name);
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || hi8 !== 8'(exp_hi8) || lo8 !== 8'(exp_lo8) || dbz8 !== exp_dz8) begin
            errors++;
            $display("FAIL %s idle_hold: got done=%b busy=%b hi=%h lo=%h dz=%b, want 0 0 %h %h %b",
                     name, done8, busy8, hi8, lo8, dbz8, 8'(exp_hi8), 8'(exp_lo8), exp_dz8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; code8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; code3 = 1'b0; a3 = '0; b3 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0 || {busy3, done3, dbz3, hi3, lo3} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: w8=%h w3=%h, want all zero",
                     {busy8, done8, dbz8, hi8, lo8}, {busy3, done3, dbz3, hi3, lo3});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        issue8(1'b0, 8'd13, 8'd11);
        finish8(1'b0, 8'd13, 8'd11, 1'b0, "mul_13x11");
        check_hold8("mul_13x11");
        issue8(1'b0, 8'd0, 8'd200);
        finish8(1'b0, 8'd0, 8'd200, 1'b0, "mul_zero_a");
        check_hold8("mul_zero_a");
    endtask

    task automatic test_back_to_back();
        issue8(1'b0, 8'd255, 8'd255);
        finish8(1'b0, 8'd255, 8'd255, 1'b1, "mul_255x255");
        issue8(1'b1, 8'd200, 8'd7);
        finish8(1'b1, 8'd200, 8'd7, 1'b1, "div_200_7_b2b");
        issue8(1'b1, 8'd3, 8'd9);
        finish8(1'b1, 8'd3, 8'd9, 1'b0, "div_a_lt_b");
        check_hold8("div_a_lt_b");
    endtask

    task automatic test_div_by_zero();
        issue8(1'b1, 8'd5, 8'd0);
        finish8(1'b1, 8'd5, 8'd0, 1'b0, "div_5_0");
        check_hold8("div_5_0");
        check_hold8("div_5_0_2");
        issue8(1'b0, 8'd6, 8'd7);
        finish8(1'b0, 8'd6, 8'd7, 1'b0, "clear_dz");
        check_hold8("clear_dz");
    endtask

    task automatic test_early_exit();
        issue8(1'b0, 8'd77, 8'd1);
        finish8(1'b0, 8'd77, 8'd1, 1'b0, "mul_77x1");
        issue8(1'b0, 8'd10, 8'h10);
        finish8(1'b0, 8'd10, 8'h10, 1'b0, "mul_10x16");
        issue8(1'b1, 8'd9, 8'd2);
        finish8(1'b1, 8'd9, 8'd2, 1'b0, "div_9_2");
        issue8(1'b0, 8'd33, 8'd0);
        finish8(1'b0, 8'd33, 8'd0, 1'b0, "mul_by_0");
        check_hold8("early_exit");
    endtask

    task automatic test_random();
        logic       c;
        logic [7:0] a, b;
        for (int n = 0; n < 40; n++) begin
            c = 1'($urandom);
            a = 8'($urandom);
            case ($urandom_range(3))
                0: b = 8'd0;
                1: b = 8'($urandom_range(15));
                default: b = 8'($urandom);
            endcase
            issue8(c, a, b);
            finish8(c, a, b, 1'b1, "random");
            if ($urandom_range(1) == 0) check_hold8("random");
        end
        check_hold8("random_end");
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        issue8(1'b0, 8'd13, 8'd11);
        finish8(1'b0, 8'd13, 8'd11, 1'b0, "pre_reset");
        issue8(1'b0, 8'd100, 8'd100);
        repeat (4) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid busy_before: got %b, want 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid async_clear: got %h, want 0", {busy8, done8, dbz8, hi8, lo8});
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        exp_hi8 = 0; exp_lo8 = 0; exp_dz8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid no_done: got done pulse 1, want 0");
        end
        issue8(1'b0, 8'd3, 8'd4);
        finish8(1'b0, 8'd3, 8'd4, 1'b0, "after_reset_3x4");
    endtask

    task automatic test_w3_sweep();
        int hi, lo, ec, k;
        bit dz, seen;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    ref_model(1'(c), a, b, 3, hi, lo, dz);
                    ec = exp_calc(1'(c), b, 3);
                    start3 = 1'b1; code3 = 1'(c); a3 = 3'(a); b3 = 3'(b);
                    @(posedge clk);
                    #1;
                    start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); code3 = 1'($urandom);
                    k = 0; seen = 1'b0;
                    while (!seen && k < 20) begin
                        @(negedge clk);
                        k++;
                        if (done3) seen = 1'b1;
                    end
                    checks++;
                    if (!seen || k != ec + 1) begin
                        errors++;
                        $display("FAIL w3 latency %0d op%0d %0d: done at %0d, want %0d", a, c, b, k, ec + 1);
                    end
                    checks++;
                    if (hi3 !== 3'(hi) || lo3 !== 3'(lo) || dbz3 !== dz) begin
                        errors++;
                        $display("FAIL w3 result %0d op%0d %0d: got hi=%0d lo=%0d dz=%b, want hi=%0d lo=%0d dz=%b",
                                 a, c, b, hi3, lo3, dbz3, hi, lo, dz);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_div_by_zero();
        test_early_exit();
        test_random();
        test_w3_sweep();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
